// File: rtl/pa_pkg.sv
// Shared constants and types for the processing-array sequencer slice.
package pa_pkg;

  localparam int SIZE_MAT       = 16;
  localparam int WIDTH_DATA     = 8;
  localparam int WIDTH_MDATA    = 2 * WIDTH_DATA + $clog2(SIZE_MAT);
  localparam int WIDTH_LBIT_CNT = 6;
  localparam int WIDTH_HBIT_CNT = 3;
  localparam int DRAIN_CYC      = 2 * SIZE_MAT - 1;
  localparam int WIDTH_ROW      = $clog2(SIZE_MAT);

  typedef enum logic [2:0] {IDLE, WAIT, FEED, DRAIN, UNLOAD} pa_state_e;

  typedef logic [WIDTH_LBIT_CNT-1:0] lcnt_t;
  typedef logic [WIDTH_HBIT_CNT-1:0] hcnt_t;
  typedef logic [WIDTH_ROW-1:0]      row_t;

endpackage

// File: rtl/pa_seq_ctrl_if.sv
// Job control, operand pacing and result-unload signals of the sequencer.
interface pa_seq_ctrl_if;
  import pa_pkg::*;

  logic  start_i;
  hcnt_t num_tiles_i;
  logic  data_rdy_i;
  logic  read_en_o;
  logic  pe_en_o;
  logic  acc_clr_o;
  logic  zero_in_o;
  logic  out_vld_o;
  row_t  out_row_o;
  logic  out_rdy_i;
  logic  busy_o;
  logic  done_o;

  modport master (
    input  start_i, num_tiles_i, data_rdy_i, out_rdy_i,
    output read_en_o, pe_en_o, acc_clr_o, zero_in_o,
    output out_vld_o, out_row_o, busy_o, done_o
  );

  modport slave (
    output start_i, num_tiles_i, data_rdy_i, out_rdy_i,
    input  read_en_o, pe_en_o, acc_clr_o, zero_in_o,
    input  out_vld_o, out_row_o, busy_o, done_o
  );

endinterface

// File: rtl/pa_ctrl_cnt.sv
// Up-counter with enable, synchronous clear (dominant) and a terminal-count flag.
module pa_ctrl_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] max_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == max_i);

endmodule

// File: rtl/pa_seq_ctrl.sv
// Sequencer for the output-stationary array: feeds 1..8 K-tiles, drains the
// wavefront with zero fill, then unloads SIZE_MAT result rows under valid/ready.
module pa_seq_ctrl
  import pa_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  pa_seq_ctrl_if.master bus
);

  pa_state_e state_q, state_d;
  hcnt_t     num_tiles_q;
  lcnt_t     lcnt, lcnt_max;
  hcnt_t     hcnt;
  logic      lcnt_en, lcnt_clr, lcnt_tc;
  logic      hcnt_en, hcnt_clr, hcnt_tc;
  logic      start_ok, rd, hs;
  logic      rd_q, clr_q, done_q;

  assign start_ok = (state_q == IDLE) && bus.start_i;
  assign rd       = (state_q == FEED) && bus.data_rdy_i;
  assign hs       = (state_q == UNLOAD) && bus.out_rdy_i;

  // lcnt is shared: vector count in FEED, cycle count in DRAIN, row index in UNLOAD.
  assign lcnt_max = (state_q == DRAIN) ? lcnt_t'(DRAIN_CYC - 1) : lcnt_t'(SIZE_MAT - 1);
  assign lcnt_en  = rd || (state_q == DRAIN) || hs;
  assign lcnt_clr = start_ok || (lcnt_en && lcnt_tc);
  assign hcnt_en  = rd && lcnt_tc && !hcnt_tc;
  assign hcnt_clr = start_ok;

  pa_ctrl_cnt #(.WIDTH(WIDTH_LBIT_CNT)) u_lcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (lcnt_en),
    .clr_i (lcnt_clr),
    .max_i (lcnt_max),
    .cnt_o (lcnt),
    .tc_o  (lcnt_tc)
  );

  pa_ctrl_cnt #(.WIDTH(WIDTH_HBIT_CNT)) u_hcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (hcnt_en),
    .clr_i (hcnt_clr),
    .max_i (num_tiles_q),
    .cnt_o (hcnt),
    .tc_o  (hcnt_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num_tiles_q <= '0;
      rd_q        <= 1'b0;
      clr_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        num_tiles_q <= bus.num_tiles_i;
      end
      rd_q   <= rd;
      // Only tile 0 overwrites the accumulators; later tiles add in place.
      clr_q  <= rd && (hcnt == '0);
      done_q <= hs && lcnt_tc;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = WAIT;
      WAIT:    state_d = FEED;
      FEED:    if (rd && lcnt_tc && hcnt_tc) state_d = DRAIN;
      DRAIN:   if (lcnt_tc) state_d = UNLOAD;
      UNLOAD:  if (hs && lcnt_tc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The first DRAIN cycle still carries the last real vector (rd_q set).
  always_comb begin
    bus.read_en_o = rd;
    bus.pe_en_o   = rd_q || (state_q == DRAIN);
    bus.acc_clr_o = clr_q;
    bus.zero_in_o = (state_q == DRAIN) && !rd_q;
    bus.out_vld_o = (state_q == UNLOAD);
    bus.out_row_o = (state_q == UNLOAD) ? row_t'(lcnt) : '0;
    bus.busy_o    = (state_q != IDLE);
    bus.done_o    = done_q;
  end

endmodule

// File: doc/pa_seq_ctrl.md
Name: pa_seq_ctrl

Overview:
- Sequencer for the output-stationary processing array (pa_top datapath).
- Paces the upstream operand buffers via read_en_o/data_rdy_i and streams 1..8 K-tiles of SIZE_MAT vectors through the array.
- Accumulates in place, drains the wavefront with zero-fill, then unloads SIZE_MAT result rows to a downstream consumer under valid/ready.

Parameters:
SIZE_MAT, 16, array dimension; vectors per tile and result rows per job
WIDTH_LBIT_CNT, 6, width of the in-phase cycle/row counter; must hold max(SIZE_MAT, DRAIN_CYC)
WIDTH_HBIT_CNT, 3, width of the tile counter; a job is 1..2**WIDTH_HBIT_CNT tiles
DRAIN_CYC, 2*SIZE_MAT-1, wavefront drain cycles after the last tile

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start_i  in  1  job start pulse; sampled only in IDLE
num_tiles_i  in  WIDTH_HBIT_CNT  tiles-1 for the job; latched on accepted start
data_rdy_i  in  1  upstream holds a valid vector for this cycle's read
read_en_o  out  1  pop one v/h vector pair; bus is valid one cycle later
pe_en_o  out  1  array MAC/shift enable
acc_clr_o  out  1  first-MAC accumulator clear (overwrite instead of add)
zero_in_o  out  1  array input mux selects zero (drain bubbles)
out_vld_o  out  1  result row valid
out_row_o  out  $clog2(SIZE_MAT)  index of the row being unloaded
out_rdy_i  in  1  downstream accepts row
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse at job end

Behaviour:
- Reset: state=IDLE; all counters 0; every output 0. Reset mid-job aborts immediately with no done_o; the next start_i is accepted normally.
- FSM: IDLE, WAIT, FEED, DRAIN, UNLOAD.
- IDLE: start_i=1 -> latch num_tiles_i, tile_cnt=0, lcnt=0 -> WAIT. A start_i while not IDLE is ignored.
- WAIT -> FEED unconditionally on the next edge, one cycle only.
- FEED: read_en_o = data_rdy_i (Mealy). lcnt increments on each read.
  - data_rdy_i=0 stalls: no read, no pe_en one cycle later, array frozen.
  - On the read with lcnt==SIZE_MAT-1: lcnt=0.
    - If tile_cnt<num_tiles: tile_cnt++ and stay in FEED (back-to-back tiles, no gap).
    - Else -> DRAIN.
- rd_d1 = read_en_o registered. pe_en_o = rd_d1 | (state==DRAIN).
- acc_clr_o = rd_d1 during tile 0 only, i.e. the first SIZE_MAT pe_en cycles of the job.
- DRAIN: exactly DRAIN_CYC cycles, pe_en_o=1. zero_in_o = (state==DRAIN) & !rd_d1, so the first drain cycle carries the last real vector. After DRAIN_CYC cycles -> UNLOAD with lcnt=0.
- UNLOAD: out_vld_o=1, out_row_o=lcnt[..]. On out_vld_o & out_rdy_i, lcnt++.
  - The handshake at row SIZE_MAT-1 -> IDLE, done_o=1 in the following cycle.
  - out_rdy_i low holds out_row_o stable; there is no timeout.
- Counters never wrap inside a phase. num_tiles_i=2**WIDTH_HBIT_CNT-1 gives 8 tiles.
- pe_en_o, acc_clr_o and zero_in_o are registered-derived; read_en_o, out_vld_o and out_row_o are decoded from state/counters.

Decomposition:
- Shared package pa_pkg holds:
  - SIZE_MAT, WIDTH_DATA, WIDTH_MDATA, WIDTH_LBIT_CNT, WIDTH_HBIT_CNT constants.
  - typedef enum pa_state_e {IDLE, WAIT, FEED, DRAIN, UNLOAD}.
  - typedefs lcnt_t and hcnt_t.
- One sub-module, pa_ctrl_cnt: parameterised up-counter with enable, synchronous clear and a terminal-count flag. Instantiated for lcnt and tile_cnt.

Test Plan:
- Single tile, data_rdy_i=1, out_rdy_i=1, start_i in cycle 0 -> WAIT c1; read_en_o c2..c17 (16 pulses); pe_en_o c3..c48; acc_clr_o c3..c18; zero_in_o c19..c48; out_vld_o c49..c64 with rows 0..15; done_o c65; busy_o c1..c64.
- num_tiles_i=2, continuous data -> 48 consecutive read_en_o pulses; acc_clr_o covers only the first 16 pe_en cycles; single DRAIN of 31; 16 unload rows; one done_o.
- data_rdy_i toggled 1/0 every cycle in FEED -> exactly 16 read_en_o pulses over 31 cycles; pe_en_o mirrors read_en_o delayed one cycle; DRAIN entered only after the 16th read.
- out_rdy_i low 3 cycles at row 5 -> out_row_o held at 5; rows 0..15 each accepted once; done_o after row 15.
- start_i pulsed during FEED and DRAIN -> ignored: the job completes with one done_o, and busy_o stays high until IDLE.
- rst_n low 1 cycle mid-DRAIN -> all outputs 0 next cycle, no done_o; a new start_i then runs a full single-tile job with the same cycle counts as scenario 1.
